// File: rtl/bp_be_pkg.sv
// Shared backend types for the long-latency sequencer.
package bp_be_pkg;

   typedef enum logic [1:0] {
      e_long_idle  = 2'd0,
      e_long_start = 2'd1,
      e_long_busy  = 2'd2,
      e_long_wb    = 2'd3
   } bp_be_long_state_e;

   localparam int unsigned long_req_int_lp = 0;
   localparam int unsigned long_req_fp_lp  = 1;

endpackage

// File: rtl/bp_be_long_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is issued.
module bp_be_long_rr_arb
   import bp_be_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   // prio_fp_q=1 means the FP requester wins the next tie; reset favours integer.
   logic prio_fp_q, prio_fp_d;

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_fp_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
         endcase
      end
   end

   always_comb begin
      prio_fp_d = prio_fp_q;
      if (gnt_o[long_req_int_lp])
         prio_fp_d = 1'b1;
      else if (gnt_o[long_req_fp_lp])
         prio_fp_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) prio_fp_q <= 1'b0;
      else            prio_fp_q <= prio_fp_d;
   end

endmodule

// File: rtl/bp_be_long_sequencer.sv
// Sequencer for the shared iterative div/sqrt unit: arbitration, launch,
// in-flight hazard tracking, writeback hold, flush and hang watchdog.
//
// state | meaning
// IDLE  | waiting for a long op; ready granted here only
// START | one-cycle launch pulse to the unit, watchdog cleared
// BUSY  | unit iterating; watchdog counting, poison recorded
// WB    | result held on the writeback port until accepted
module bp_be_long_sequencer
   import bp_be_pkg::*;
#(
   parameter int reg_addr_width_p = 5,
   parameter int timeout_p        = 128
)
(
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        int_v_i,
   input  logic [reg_addr_width_p-1:0] int_rd_addr_i,
   output logic                        int_ready_o,
   input  logic                        fp_v_i,
   input  logic [reg_addr_width_p-1:0] fp_rd_addr_i,
   output logic                        fp_ready_o,
   input  logic                        poison_i,
   output logic                        unit_start_o,
   output logic                        unit_fp_o,
   input  logic                        unit_done_i,
   output logic                        wb_v_o,
   input  logic                        wb_ready_i,
   output logic [reg_addr_width_p-1:0] wb_rd_addr_o,
   output logic                        wb_fp_o,
   output logic                        long_busy_o,
   output logic                        haz_v_o,
   output logic [reg_addr_width_p-1:0] haz_rd_addr_o,
   output logic                        haz_fp_o,
   output logic                        err_o
);

   localparam int cnt_width_p = $clog2(timeout_p + 1);
   localparam logic [cnt_width_p-1:0] cnt_max_lp = cnt_width_p'(timeout_p);

   bp_be_long_state_e             state_q, state_d;
   logic                          poisoned_q, poisoned_d;
   logic [cnt_width_p-1:0]        cnt_q, cnt_d;
   logic [reg_addr_width_p-1:0]   rd_q, rd_d;
   logic                          fp_q, fp_d;
   logic                          err_q, err_d;

   logic       arb_en;
   logic [1:0] arb_gnt;

   assign arb_en = (state_q == e_long_idle) & ~poison_i;

   bp_be_long_rr_arb u_arb (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .en_i      (arb_en),
      .req_i     ({fp_v_i, int_v_i}),
      .gnt_o     (arb_gnt)
   );

   assign int_ready_o = arb_gnt[long_req_int_lp];
   assign fp_ready_o  = arb_gnt[long_req_fp_lp];

   always_comb begin
      state_d    = state_q;
      poisoned_d = poisoned_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      fp_d       = fp_q;
      err_d      = err_q;
      unique case (state_q)
         e_long_idle: begin
            if (|arb_gnt) begin
               rd_d       = arb_gnt[long_req_fp_lp] ? fp_rd_addr_i : int_rd_addr_i;
               fp_d       = arb_gnt[long_req_fp_lp];
               poisoned_d = 1'b0;
               state_d    = e_long_start;
            end
         end
         e_long_start: begin
            cnt_d = '0;
            if (poison_i) poisoned_d = 1'b1;
            state_d = e_long_busy;
         end
         e_long_busy: begin
            if (poison_i) poisoned_d = 1'b1;
            if (cnt_q != cnt_max_lp) cnt_d = cnt_q + cnt_width_p'(1);
            if (!unit_done_i && (cnt_d == cnt_max_lp)) err_d = 1'b1;
            // A flush arriving with done still drops the result.
            if (unit_done_i)
               state_d = (poisoned_q | poison_i) ? e_long_idle : e_long_wb;
         end
         e_long_wb: begin
            if (wb_ready_i) state_d = e_long_idle;
         end
         default: state_d = e_long_idle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= e_long_idle;
         poisoned_q <= 1'b0;
         cnt_q      <= '0;
         rd_q       <= '0;
         fp_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         poisoned_q <= poisoned_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         fp_q       <= fp_d;
         err_q      <= err_d;
      end
   end

   assign long_busy_o   = (state_q != e_long_idle);
   assign unit_start_o  = (state_q == e_long_start);
   assign unit_fp_o     = fp_q & long_busy_o;
   assign wb_v_o        = (state_q == e_long_wb);
   assign wb_rd_addr_o  = rd_q;
   assign wb_fp_o       = fp_q;
   assign haz_v_o       = long_busy_o & ~poisoned_q & ~(wb_v_o & wb_ready_i);
   assign haz_rd_addr_o = rd_q;
   assign haz_fp_o      = fp_q;
   assign err_o         = err_q;

endmodule

// File: doc/bp_be_long_sequencer.md
# bp_be_long_sequencer

Sequences the backend's shared iterative long-latency unit (integer div/rem and FP div/sqrt). It arbitrates between the integer and FP long-op requesters and launches the unit. It tracks the in-flight destination so the dispatch checker can raise `long_busy` and detect data hazards. It holds the result writeback until the writeback port accepts it, and it handles pipeline flush (poison) and a hang watchdog.

## Interface
Parameters:
- `reg_addr_width_p`, 5, destination register address width
- `timeout_p`, 128, BUSY cycles without `unit_done_i` before `err_o` sets
- `cnt_width_p`, `$clog2(timeout_p+1)`, watchdog counter width (localparam)

Ports:
- `clk_i`  in  1  clock, all state on rising edge
- `reset_n_i`  in  1  asynchronous, active-low reset
- `int_v_i`  in  1  integer long op requests issue
- `int_rd_addr_i`  in  `reg_addr_width_p`  integer destination
- `int_ready_o`  out  1  integer request accepted this cycle (valid & ready)
- `fp_v_i`  in  1  FP long op requests issue
- `fp_rd_addr_i`  in  `reg_addr_width_p`  FP destination
- `fp_ready_o`  out  1  FP request accepted this cycle
- `poison_i`  in  1  flush: kill in-flight, uncommitted op
- `unit_start_o`  out  1  one-cycle launch pulse to the iterative unit
- `unit_fp_o`  out  1  operation class for the unit (0 int, 1 FP), valid whenever not IDLE
- `unit_done_i`  in  1  unit result valid (single-cycle pulse)
- `wb_v_o`  out  1  writeback request
- `wb_ready_i`  in  1  writeback port accepts
- `wb_rd_addr_o`  out  `reg_addr_width_p`  writeback destination
- `wb_fp_o`  out  1  writeback targets the FP regfile
- `long_busy_o`  out  1  sequencer not IDLE (structural hazard)
- `haz_v_o`  out  1  live (non-poisoned) destination pending
- `haz_rd_addr_o`  out  `reg_addr_width_p`  pending destination
- `haz_fp_o`  out  1  pending destination is FP
- `err_o`  out  1  sticky watchdog error

## Operation
- States: IDLE, START, BUSY, WB. Reset: IDLE. All outputs are 0 on reset. Round-robin pointer resets so integer wins the first tie. Poisoned flag, counter, latched rd/fp and `err_o` all reset to 0.
- IDLE:
  - Ready is granted only if `~poison_i`.
  - If exactly one valid, that requester gets ready. If both are valid, the requester not granted last gets ready.
  - On handshake: latch rd and class, update the pointer, clear poisoned, go to START.
- START: `unit_start_o`=1 for exactly this cycle. Counter is cleared. Next state is BUSY.
- BUSY:
  - Counter increments, saturating at `timeout_p`.
  - On `unit_done_i`: if poisoned, go to IDLE (no writeback); else go to WB.
  - On reaching `timeout_p`, `err_o` sets (sticky until reset). The FSM stays BUSY waiting for done.
- WB:
  - `wb_v_o`=1 with the latched rd/fp. They must hold stable until `wb_ready_i`.
  - On `wb_ready_i`: go to IDLE.
- Poison:
  - In START or BUSY, poison sets the poisoned flag. The unit cannot abort, so the FSM continues to done and then drops the result.
  - In WB, poison is ignored: the result is already committed.
  - In IDLE, poison blocks acceptance that cycle.
- `unit_done_i` outside BUSY is ignored.
- `haz_v_o` = (state != IDLE) & ~poisoned & (state != WB || ~wb_ready_i). The outputs are combinational from the registered state and flag.
- `long_busy_o` = (state != IDLE).

## Timing
- Handshake in cycle N → `unit_start_o` in N+1 → BUSY from N+2. The earliest honoured done is N+2, giving `wb_v_o` at N+3.
- Back-to-back ops: a new accept is possible in the same cycle the FSM returns to IDLE's next cycle. The minimum issue-to-issue interval is 4 cycles.
- Ready outputs are combinational from state, the valids and `poison_i`.
- No combinational path exists from `wb_ready_i` or `unit_done_i` to the ready outputs.
- Reset asserted mid-operation forces IDLE immediately and deasserts all outputs, with no writeback.

## Structure
- `bp_be_long_state_e` (IDLE/START/BUSY/WB) is defined in `bp_be_pkg`.
- Sub-module `bp_be_long_rr_arb` is a 2-way round-robin arbiter. It has an enable, a grant one-hot and a pointer register (async active-low reset).
- The FSM, watchdog counter and latches live in the top level.

## Test plan
- Single integer op, rd=7, done 10 cycles after start, `wb_ready_i`=1:
  - `int_ready_o` at N, start at N+1, `haz_v_o`=1 with rd=7 until WB.
  - `wb_v_o` with rd=7 and `wb_fp_o`=0 is seen for 1 cycle.
- `int_v_i` and `fp_v_i` both held high continuously:
  - Grants alternate int, fp, int, fp.
  - Each grant waits for the previous writeback to complete.
- Poison in BUSY:
  - `haz_v_o` drops the next cycle and `long_busy_o` stays 1.
  - On done the FSM returns to IDLE with `wb_v_o` never asserted.
- WB backpressure:
  - With `wb_ready_i`=0 for 5 cycles, `wb_v_o` and rd stay stable and both ready outputs stay 0.
  - Poison during WB is ignored and the writeback completes.
- Watchdog:
  - No done for 128 BUSY cycles sets `err_o`=1.
  - A later done completes the writeback, and `err_o` stays 1 until `reset_n_i` is asserted.
- Reset asserted in BUSY: all outputs are 0 asynchronously, and the first tie after release grants int.
